// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature encoder counter: per-channel synchroniser, glitch filter,
// gray-code step decode and up/down counter, plus sticky error flags and atomic snapshot.
module quad_decoder_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*CHANNELS-1:0]     q,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       clr,
  input  logic                      latch,
  input  logic                      err_clr,
  output logic [WIDTH*CHANNELS-1:0] count,
  output logic [WIDTH*CHANNELS-1:0] snap,
  output logic [CHANNELS-1:0]       err
);

  localparam int unsigned RunW = $clog2(FILTER_LEN + 1);

  // Marks when the synchroniser holds real samples rather than reset zeros, so the
  // first accepted value is the true encoder state.
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   s_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_q <= '0;
    end else begin
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s_valid = prime_q[SYNC_STAGES-1];

  function automatic logic [1:0] phase(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]       sync_q [SYNC_STAGES];
    logic [1:0]       s;
    logic [1:0]       last_q;
    logic [RunW-1:0]  run_q, run_d;
    logic             accept;
    logic [1:0]       a_q;
    logic             acc_q;
    logic             init_q;
    logic [1:0]       p_q;
    logic [1:0]       diff;
    logic             changed, step_fwd, step_rev, step_bad;
    logic [WIDTH-1:0] cnt_q, cnt_d, snap_q;
    logic             err_q, err_d;

    assign s = sync_q[SYNC_STAGES-1];

    // run counts consecutive identical synced samples, saturating at FILTER_LEN.
    always_comb begin
      run_d = RunW'(1);
      if (run_q != '0 && s == last_q) begin
        run_d = (run_q >= RunW'(FILTER_LEN)) ? run_q : run_q + RunW'(1);
      end
    end

    assign accept   = s_valid && (run_d >= RunW'(FILTER_LEN));
    assign diff     = phase(a_q) - phase(p_q);
    assign changed  = acc_q && !init_q && (a_q != p_q);
    assign step_fwd = changed && (diff == 2'd1);
    assign step_rev = changed && (diff == 2'd3);
    assign step_bad = changed && (diff == 2'd2);

    always_comb begin
      cnt_d = cnt_q;
      if (clr[i]) begin
        cnt_d = '0;
      end else if (step_fwd && (mode[i] || p_q == 2'b10)) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (step_rev && (mode[i] || p_q == 2'b00)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end

    always_comb begin
      err_d = err_q;
      if (step_bad) begin
        err_d = 1'b1;
      end else if (err_clr) begin
        err_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
          sync_q[k] <= '0;
        end
        last_q <= '0;
        run_q  <= '0;
        a_q    <= '0;
        acc_q  <= 1'b0;
        init_q <= 1'b1;
        p_q    <= '0;
        cnt_q  <= '0;
        snap_q <= '0;
        err_q  <= 1'b0;
      end else begin
        sync_q[0] <= q[2*i +: 2];
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
        if (s_valid) begin
          last_q <= s;
          run_q  <= run_d;
        end
        if (accept) begin
          a_q   <= s;
          acc_q <= 1'b1;
        end
        // The first accepted value only seeds the previous state.
        if (acc_q && init_q) begin
          p_q    <= a_q;
          init_q <= 1'b0;
        end else if (changed) begin
          p_q <= a_q;
        end
        cnt_q <= cnt_d;
        err_q <= err_d;
        if (latch) begin
          snap_q <= cnt_q;
        end
      end
    end

    assign count[WIDTH*i +: WIDTH] = cnt_q;
    assign snap[WIDTH*i +: WIDTH]  = snap_q;
    assign err[i]                  = err_q;
  end

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Scoreboard bench for quad_decoder_multi: stimulus pushes timed expectations from an
// edge-position reference model; a negedge monitor compares them against the outputs.
module tb_quad_decoder_multi;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int S  = 2;
  localparam int F  = 2;
  localparam int L  = S + F + 1;
  localparam longint BASE = 64'd1 << 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*CH-1:0] q;
  logic [CH-1:0]   mode, clr;
  logic            latch, err_clr;
  logic [W*CH-1:0] count, snap;
  logic [CH-1:0]   err;

  quad_decoder_multi #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .SYNC_STAGES(S),
    .FILTER_LEN (F)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .q      (q),
    .mode   (mode),
    .clr    (clr),
    .latch  (latch),
    .err_clr(err_clr),
    .count  (count),
    .snap   (snap),
    .err    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int due;
    int ch;
    int kind;  // 0 count, 1 snap, 2 err
    int val;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  int     mcount[CH];
  longint mpos[CH];
  logic [1:0] mq[CH];

  function automatic int ph(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray(input int p);
    logic [1:0] b;
    b = p[1:0];
    return {b[1], b[1] ^ b[0]};
  endfunction

  function automatic string kname(input int k);
    case (k)
      0:       return "count";
      1:       return "snap";
      default: return "err";
    endcase
  endfunction

  task automatic expect_at(input int off, input int ch, input int kind, input int val);
    exp_t e;
    e.due  = cyc + off;
    e.ch   = ch;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mcount[c] = 0;
      mq[c]     = q[2*c +: 2];
      mpos[c]   = BASE + longint'(ph(mq[c]));
    end
  endtask

  // Drive a new encoder state on one channel and predict the count it produces.
  task automatic step(input int ch, input logic [1:0] n, input bit lost);
    int     d;
    int     delta;
    longint np;
    d = (ph(n) - ph(mq[ch]) + 4) % 4;
    q[2*ch +: 2] = n;
    if (d == 2) begin
      expect_at(L, ch, 2, 1);
      expect_at(L, ch, 0, mcount[ch]);
      mpos[ch] = mpos[ch] + 2;
    end else if (d != 0) begin
      np    = mpos[ch] + ((d == 1) ? 1 : -1);
      delta = mode[ch] ? int'(np - mpos[ch]) : int'(np / 4 - mpos[ch] / 4);
      mpos[ch] = np;
      if (!lost) begin
        expect_at(L - 1, ch, 0, mcount[ch]);
        mcount[ch] = (mcount[ch] + delta) & 32'hFFFF;
        expect_at(L, ch, 0, mcount[ch]);
      end
    end
    mq[ch] = n;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int act;
    for (int i = 0; i < sb.size();) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          0:       act = int'(count[W*sb[i].ch +: W]);
          1:       act = int'(snap[W*sb[i].ch +: W]);
          default: act = int'(err[sb[i].ch]);
        endcase
        checks++;
        if (act != sb[i].val) begin
          errors++;
          $display("FAIL %s ch%0d cyc %0d: got %0h expected %0h",
                   kname(sb[i].kind), sb[i].ch, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  int tmr[CH];
  int last[CH];

  initial begin
    q = '0; mode = '1; clr = '0; latch = 1'b0; err_clr = 1'b0; rst = 1'b0;
    tick(3);
    model_reset();
    for (int c = 0; c < CH; c++) begin
      expect_at(0, c, 0, 0);
      expect_at(0, c, 1, 0);
      expect_at(0, c, 2, 0);
    end
    rst = 1'b1;
    tick(12);

    // Full-resolution forward cycle on ch0 with exact latency.
    step(0, 2'b01, 1'b0); tick(16);
    step(0, 2'b11, 1'b0); tick(16);
    step(0, 2'b10, 1'b0); tick(16);
    step(0, 2'b00, 1'b0); tick(16);

    // div4: 40 forward then 41 reverse edges.
    mode[0] = 1'b0;
    clr[0] = 1'b1; mcount[0] = 0; expect_at(1, 0, 0, 0);
    tick(1); clr = '0; tick(2);
    for (int i = 0; i < 40; i++) begin
      step(0, gray((ph(mq[0]) + 1) % 4), 1'b0); tick(3);
    end
    tick(L + 1);
    expect_at(0, 0, 0, 10);
    for (int i = 0; i < 41; i++) begin
      step(0, gray((ph(mq[0]) + 3) % 4), 1'b0); tick(3);
    end
    tick(L + 1);
    expect_at(0, 0, 0, 32'hFFFF);
    expect_at(0, 0, 2, 0);
    tick(1);

    // Glitch rejection, then illegal jump and err_clr on ch1.
    q[3:2] = 2'b01; tick(1);
    q[3:2] = 2'b00; tick(L + 4);
    expect_at(0, 1, 0, 0);
    expect_at(0, 1, 2, 0);
    step(1, 2'b11, 1'b0); tick(L + 3);
    expect_at(0, 1, 2, 1);
    err_clr = 1'b1; expect_at(1, 1, 2, 0);
    tick(1); err_clr = 1'b0; tick(3);

    // q = 11 held through reset release: no count, no err; then 11->10 counts.
    q = '1; tick(1);
    rst = 1'b0; tick(2);
    model_reset(); mode = '1;
    expect_at(0, 0, 0, 0);
    expect_at(0, 1, 2, 0);
    rst = 1'b1; tick(15);
    expect_at(0, 0, 0, 0);
    expect_at(0, 0, 2, 0);
    step(0, 2'b10, 1'b0); tick(L + 2);
    expect_at(0, 0, 0, 1);
    tick(1);

    // latch + clr[2] colliding with a pending step at count2 = 5.
    step(2, 2'b10, 1'b0); tick(8);
    step(2, 2'b00, 1'b0); tick(8);
    step(2, 2'b01, 1'b0); tick(8);
    step(2, 2'b11, 1'b0); tick(8);
    step(2, 2'b10, 1'b0); tick(8);
    step(2, 2'b00, 1'b1); tick(L - 1);
    latch = 1'b1; clr = 4'b0100;
    expect_at(1, 2, 1, 5);
    expect_at(1, 2, 0, 0);
    for (int c = 0; c < CH; c++) if (c != 2) expect_at(1, c, 1, mcount[c]);
    mcount[2] = 0;
    tick(1); latch = 1'b0; clr = '0; tick(4);
    step(2, 2'b01, 1'b0); tick(L + 2);
    expect_at(0, 2, 0, 1);
    tick(1);

    // Random walk on all channels with random per-channel mode.
    for (int c = 0; c < CH; c++) begin
      tmr[c]  = $urandom_range(2, 7);
      last[c] = cyc;
    end
    repeat (20000) begin
      for (int c = 0; c < CH; c++) begin
        if (tmr[c] == 0) begin
          if (cyc - last[c] > L && $urandom_range(0, 7) == 0) mode[c] = ~mode[c];
          step(c, gray((ph(mq[c]) + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4), 1'b0);
          last[c] = cyc;
          tmr[c]  = $urandom_range(2, 7);
        end else begin
          tmr[c]--;
        end
      end
      tick(1);
    end
    tick(L + 2);
    for (int c = 0; c < CH; c++) begin
      expect_at(0, c, 0, mcount[c]);
      expect_at(0, c, 2, 0);
    end
    tick(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
